// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point compress/expand path.
// Holds default field widths, the expander state type and the packed S/E/F word.
package fp_pkg;

  localparam int unsigned DefExpW = 3;
  localparam int unsigned DefManW = 4;
  localparam int unsigned DefOutW = 12;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StSign,
    StDone
  } fp_state_e;

  typedef struct packed {
    logic               s;
    logic [DefExpW-1:0] e;
    logic [DefManW-1:0] f;
  } fp_word_t;

endpackage

// File: rtl/fp_twos_negate.sv
// Combinational conditional two's-complement negate of an unsigned magnitude.
// Shared between the expander output stage and the compressor magnitude stage.
module fp_twos_negate
  import fp_pkg::*;
#(
  parameter int unsigned OUT_W = DefOutW
) (
  input  logic             neg_i,
  input  logic [OUT_W-1:0] mag_i,
  output logic [OUT_W-1:0] d_o
);

  always_comb begin
    d_o = neg_i ? (~mag_i + OUT_W'(1)) : mag_i;
  end

endmodule

// File: rtl/fp_expand_seq.sv
// Sequential float-to-linear expander: rebuilds a two's-complement sample from S/E/F
// using a one-bit-per-cycle shifter, with valid/ready on both sides.
module fp_expand_seq
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = DefExpW,
  parameter int unsigned MAN_W = DefManW,
  parameter int unsigned OUT_W = DefOutW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic [EXP_W-1:0] E,
  input  logic [MAN_W-1:0] F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] D,
  output logic             busy
);

  // The widest mantissa shifted by the largest exponent must fit the output.
  if (OUT_W < MAN_W + (1 << EXP_W)) begin : g_bad_cfg
    $fatal(1, "fp_expand_seq: OUT_W too small for MAN_W + 2**EXP_W");
  end

  fp_state_e        state_q, state_d;
  logic [OUT_W-1:0] mag_q, mag_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic [OUT_W-1:0] d_q, d_d;
  logic [OUT_W-1:0] signed_mag;

  fp_twos_negate #(
    .OUT_W (OUT_W)
  ) u_negate (
    .neg_i (sign_q),
    .mag_i (mag_q),
    .d_o   (signed_mag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      mag_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    d_d     = d_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d  = S;
          cnt_d   = E;
          mag_d   = OUT_W'(F);
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q == '0) begin
          state_d = StSign;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - EXP_W'(1);
        end
      end
      StSign: begin
        d_d     = signed_mag;
        state_d = StDone;
      end
      StDone: begin
        // D is left holding the last result after the handoff.
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    D         = d_q;
  end

endmodule

// File: tb/tb_fp_expand_seq.sv
// Directed self-checking bench for fp_expand_seq with hand-computed results.
module tb_fp_expand_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D;
  logic        busy;

  int checks;
  int errors;

  fp_expand_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one word and counts edges (accept edge = 1) until out_valid rises.
  task automatic convert(input logic s, input logic [2:0] e, input logic [3:0] f,
                         output int lat, output logic [11:0] d);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    in_valid = 1'b1;
    S = s;
    E = e;
    F = f;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    d = D;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || D !== 12'h000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b D=%h busy=%b, want 1 0 000 0",
               in_ready, out_valid, D, busy);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int lat;
    logic [11:0] d;
    convert(1'b0, 3'd0, 4'd5, lat, d);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 3", lat);
    end
    checks++;
    if (d !== 12'h005) begin
      errors++;
      $display("FAIL basic_d: got %h want 005", d);
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_flags: busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_return_idle: in_ready=%b out_valid=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_values();
    logic        vs [4];
    logic [2:0]  ve [4];
    logic [3:0]  vf [4];
    logic [11:0] vd [4];
    int          vl [4];
    int          lat;
    logic [11:0] d;
    vs = '{1'b1, 1'b1, 1'b1, 1'b0};
    ve = '{3'd7, 3'd2, 3'd3, 3'd7};
    vf = '{4'd15, 4'd13, 4'd0, 4'd1};
    vd = '{12'h880, 12'hFCC, 12'h000, 12'h080};
    vl = '{10, 5, 6, 10};
    for (int i = 0; i < 4; i++) begin
      convert(vs[i], ve[i], vf[i], lat, d);
      checks++;
      if (d !== vd[i]) begin
        errors++;
        $display("FAIL values_d[%0d]: got %h want %h", i, d, vd[i]);
      end
      checks++;
      if (lat !== vl[i]) begin
        errors++;
        $display("FAIL values_latency[%0d]: got %0d want %0d", i, lat, vl[i]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [11:0] d;
    out_ready = 1'b0;
    convert(1'b0, 3'd1, 4'd3, lat, d);
    checks++;
    if (d !== 12'h006 || lat !== 4) begin
      errors++;
      $display("FAIL bp_result: d=%h lat=%0d want 006 4", d, lat);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || D !== 12'h006 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: out_valid=%b D=%h in_ready=%b want 1 006 0",
                 i, out_valid, D, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== 12'h006) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b D=%h want 0 1 006",
               out_valid, in_ready, D);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    in_valid = 1'b1;
    S = 1'b0;
    E = 3'd4;
    F = 4'd9;
    step();
    lat = 1;
    S = 1'b1;
    E = 3'd7;
    F = 4'd15;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL ignore_in_ready[%0d]: got %b want 0", i, in_ready);
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (D !== 12'h090 || lat !== 7) begin
      errors++;
      $display("FAIL ignore_result: D=%h lat=%0d want 090 7", D, lat);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_reaccept: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [11:0] d;
    in_valid = 1'b1;
    S = 1'b0;
    E = 3'd6;
    F = 4'd1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || D !== 12'h000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b D=%h busy=%b want 1 0 000 0",
               in_ready, out_valid, D, busy);
    end
    #2;
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stays_idle: busy=%b out_valid=%b want 0 0", busy, out_valid);
    end
    convert(1'b1, 3'd1, 4'd1, lat, d);
    checks++;
    if (d !== 12'hFFE || lat !== 4) begin
      errors++;
      $display("FAIL reset_mid_next: d=%h lat=%0d want ffe 4", d, lat);
    end
    step();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    S         = 1'b0;
    E         = '0;
    F         = '0;
    out_ready = 1'b1;
    test_reset();
    test_basic();
    test_values();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
